// File: rtl/voice_allocator.sv
// Polyphony allocator: maps note-on/off events onto NUM_VOICES channels, stealing the
// oldest sounding voice when all are busy, and sequences rst_div for phase-clean restarts.
module voice_allocator #(
   parameter int NUM_VOICES     = 4,
   parameter int PITCH_W        = 12,
   parameter int AGE_W          = 3,
   parameter int RST_DIV_CYCLES = 4
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          ev_valid,
   output logic                          ev_ready,
   input  logic                          ev_on,
   input  logic [PITCH_W-1:0]            ev_pitch,
   input  logic [1:0]                    waveform_sel,
   output logic [NUM_VOICES*PITCH_W-1:0] voice_pitch,
   output logic [NUM_VOICES*2-1:0]       voice_wave,
   output logic [NUM_VOICES-1:0]         voice_ena,
   output logic [NUM_VOICES-1:0]         voice_rst_div,
   output logic                          steal,
   output logic [2:0]                    dbg_state
);

   localparam int IDX_W = $clog2(NUM_VOICES);
   localparam int CNT_W = $clog2(RST_DIV_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(RST_DIV_CYCLES - 1);
   localparam logic [AGE_W-1:0] AGE_MAX  = {AGE_W{1'b1}};

   typedef enum logic [2:0] {
      S_INIT   = 3'd0,
      S_IDLE   = 3'd1,
      S_LOOKUP = 3'd2,
      S_APPLY  = 3'd3,
      S_HOLD   = 3'd4
   } state_t;

   state_t state, state_nxt;

   logic [PITCH_W-1:0] pitch_r [NUM_VOICES];
   logic [1:0]         wave_r  [NUM_VOICES];
   logic [AGE_W-1:0]   age_r   [NUM_VOICES];
   logic [CNT_W-1:0]   cnt;

   logic               ev_on_q;
   logic [PITCH_W-1:0] ev_pitch_q;
   logic [1:0]         ev_wave_q;
   logic [IDX_W-1:0]   tgt_q;
   logic               act_q;
   logic               stl_q;

   logic               hit_found, free_found;
   logic [IDX_W-1:0]   hit_idx, free_idx, old_idx;
   logic [AGE_W-1:0]   old_age;

   // Handshake: an event transfers on a rising edge where ev_valid and ev_ready are both 1;
   // ev_ready is high only in IDLE, so the source must hold its event stable while stalled.
   always_comb begin
      state_nxt = state;
      ev_ready  = 1'b0;
      case (state)
         S_INIT:   if (cnt == '0) state_nxt = S_IDLE;
         S_IDLE: begin
            ev_ready = 1'b1;
            if (ev_valid) state_nxt = S_LOOKUP;
         end
         S_LOOKUP: state_nxt = S_APPLY;
         S_APPLY:  state_nxt = (act_q && ev_on_q) ? S_HOLD : S_IDLE;
         S_HOLD:   if (cnt == '0) state_nxt = S_IDLE;
         default:  state_nxt = S_INIT;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= S_INIT;
      else        state <= state_nxt;
   end

   assign dbg_state = state;

   // Descending scan leaves the lowest matching index; ascending strict-greater keeps
   // the lowest index among voices tied for the oldest age.
   always_comb begin
      hit_found  = 1'b0;
      hit_idx    = '0;
      free_found = 1'b0;
      free_idx   = '0;
      for (int i = NUM_VOICES - 1; i >= 0; i--) begin
         if (voice_ena[i] && (pitch_r[i] == ev_pitch_q)) begin
            hit_found = 1'b1;
            hit_idx   = IDX_W'(i);
         end
         if (!voice_ena[i]) begin
            free_found = 1'b1;
            free_idx   = IDX_W'(i);
         end
      end
      old_idx = '0;
      old_age = age_r[0];
      for (int i = 1; i < NUM_VOICES; i++) begin
         if (age_r[i] > old_age) begin
            old_age = age_r[i];
            old_idx = IDX_W'(i);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NUM_VOICES; i++) begin
            pitch_r[i] <= '0;
            wave_r[i]  <= '0;
            age_r[i]   <= '0;
         end
         voice_ena     <= '0;
         voice_rst_div <= '1;
         steal         <= 1'b0;
         cnt           <= CNT_INIT;
         ev_on_q       <= 1'b0;
         ev_pitch_q    <= '0;
         ev_wave_q     <= '0;
         tgt_q         <= '0;
         act_q         <= 1'b0;
         stl_q         <= 1'b0;
      end else begin
         steal <= 1'b0;
         case (state)
            S_INIT: begin
               if (cnt == '0) voice_rst_div <= '0;
               else           cnt <= cnt - 1'b1;
            end
            S_IDLE: begin
               if (ev_valid) begin
                  ev_on_q    <= ev_on;
                  ev_pitch_q <= ev_pitch;
                  ev_wave_q  <= waveform_sel;
               end
            end
            S_LOOKUP: begin
               stl_q <= 1'b0;
               if (ev_on_q) begin
                  act_q <= 1'b1;
                  if (hit_found)       tgt_q <= hit_idx;
                  else if (free_found) tgt_q <= free_idx;
                  else begin
                     tgt_q <= old_idx;
                     stl_q <= 1'b1;
                  end
               end else begin
                  act_q <= hit_found;
                  tgt_q <= hit_idx;
               end
            end
            S_APPLY: begin
               if (act_q && ev_on_q) begin
                  for (int j = 0; j < NUM_VOICES; j++) begin
                     if (IDX_W'(j) == tgt_q) begin
                        pitch_r[j]       <= ev_pitch_q;
                        wave_r[j]        <= ev_wave_q;
                        age_r[j]         <= '0;
                        voice_ena[j]     <= 1'b0;
                        voice_rst_div[j] <= 1'b1;
                     end else if (voice_ena[j] && (age_r[j] != AGE_MAX)) begin
                        age_r[j] <= age_r[j] + 1'b1;
                     end
                  end
                  steal <= stl_q;
                  cnt   <= CNT_INIT;
               end else if (act_q) begin
                  voice_ena[tgt_q] <= 1'b0;
                  age_r[tgt_q]     <= '0;
               end
            end
            S_HOLD: begin
               if (cnt == '0) begin
                  voice_rst_div[tgt_q] <= 1'b0;
                  voice_ena[tgt_q]     <= 1'b1;
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      voice_pitch = '0;
      voice_wave  = '0;
      for (int i = 0; i < NUM_VOICES; i++) begin
         voice_pitch[i*PITCH_W +: PITCH_W] = pitch_r[i];
         voice_wave[i*2 +: 2]              = wave_r[i];
      end
   end

endmodule

// File: tb/tb_voice_allocator.sv
// Directed bench for voice_allocator: reset/init sequence, allocation, stealing,
// retrigger, note-off, stall during HOLD and reset mid-event.
module tb_voice_allocator;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        ev_valid = 1'b0;
   logic        ev_ready;
   logic        ev_on = 1'b0;
   logic [11:0] ev_pitch = '0;
   logic [1:0]  waveform_sel = '0;
   logic [47:0] voice_pitch;
   logic [7:0]  voice_wave;
   logic [3:0]  voice_ena;
   logic [3:0]  voice_rst_div;
   logic        steal;
   logic [2:0]  dbg_state;

   int checks = 0;
   int errors = 0;

   voice_allocator #(
      .NUM_VOICES(4), .PITCH_W(12), .AGE_W(3), .RST_DIV_CYCLES(4)
   ) dut (
      .clk(clk), .rst_n(rst_n), .ev_valid(ev_valid), .ev_ready(ev_ready),
      .ev_on(ev_on), .ev_pitch(ev_pitch), .waveform_sel(waveform_sel),
      .voice_pitch(voice_pitch), .voice_wave(voice_wave), .voice_ena(voice_ena),
      .voice_rst_div(voice_rst_div), .steal(steal), .dbg_state(dbg_state)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [47:0] pp(input logic [11:0] p0, p1, p2, p3);
      return {p3, p2, p1, p0};
   endfunction

   function automatic logic [7:0] ww(input logic [1:0] w0, w1, w2, w3);
      return {w3, w2, w1, w0};
   endfunction

   task automatic wait_n(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Presents an event, waits (bounded) for ready, and returns at the negedge after the accept edge.
   task automatic send(input logic on, input logic [11:0] p, input logic [1:0] w);
      int n;
      ev_valid     = 1'b1;
      ev_on        = on;
      ev_pitch     = p;
      waveform_sel = w;
      n = 0;
      while (!ev_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      check("ready_before_accept", 64'(ev_ready), 64'd1);
      @(posedge clk);
      @(negedge clk);
      ev_valid = 1'b0;
   endtask

   initial begin
      // Reset held 3 cycles
      wait_n(3);
      check("rst_rst_div", 64'(voice_rst_div), 64'hF);
      check("rst_ena", 64'(voice_ena), 64'h0);
      check("rst_pitch", 64'(voice_pitch), 64'h0);
      check("rst_ready", 64'(ev_ready), 64'd0);
      check("rst_steal", 64'(steal), 64'd0);
      rst_n = 1'b1;
      check("init_rst_div_0", 64'(voice_rst_div), 64'hF);
      for (int i = 1; i <= 3; i++) begin
         @(negedge clk);
         check("init_rst_div", 64'(voice_rst_div), 64'hF);
         check("init_ready", 64'(ev_ready), 64'd0);
      end
      @(negedge clk);
      check("init_done_rst_div", 64'(voice_rst_div), 64'h0);
      check("init_done_ready", 64'(ev_ready), 64'd1);

      // First note-on lands on voice 0
      send(1'b1, 12'd52, 2'd1);
      check("on52_s0_ready", 64'(ev_ready), 64'd0);
      @(negedge clk);
      check("on52_s1_pitch", 64'(voice_pitch), 64'h0);
      @(negedge clk);
      check("on52_s2_pitch", 64'(voice_pitch), 64'(pp(52, 0, 0, 0)));
      check("on52_s2_wave", 64'(voice_wave), 64'(ww(1, 0, 0, 0)));
      check("on52_s2_rst_div", 64'(voice_rst_div), 64'h1);
      check("on52_s2_ena", 64'(voice_ena), 64'h0);
      wait_n(3);
      check("on52_s5_rst_div", 64'(voice_rst_div), 64'h1);
      check("on52_s5_ena", 64'(voice_ena), 64'h0);
      @(negedge clk);
      check("on52_s6_rst_div", 64'(voice_rst_div), 64'h0);
      check("on52_s6_ena", 64'(voice_ena), 64'h1);
      check("on52_s6_ready", 64'(ev_ready), 64'd1);

      // Fill remaining voices
      send(1'b1, 12'd26, 2'd2); wait_n(6);
      send(1'b1, 12'd40, 2'd3); wait_n(6);
      send(1'b1, 12'd60, 2'd0); wait_n(6);
      check("fill_pitch", 64'(voice_pitch), 64'(pp(52, 26, 40, 60)));
      check("fill_wave", 64'(voice_wave), 64'(ww(1, 2, 3, 0)));
      check("fill_ena", 64'(voice_ena), 64'hF);

      // All busy: 70 steals voice 0 (oldest)
      send(1'b1, 12'd70, 2'd2);
      check("steal70_s0_steal", 64'(steal), 64'd0);
      wait_n(2);
      check("steal70_s2_steal", 64'(steal), 64'd1);
      check("steal70_s2_pitch", 64'(voice_pitch), 64'(pp(70, 26, 40, 60)));
      check("steal70_s2_wave", 64'(voice_wave), 64'(ww(2, 2, 3, 0)));
      check("steal70_s2_ena", 64'(voice_ena), 64'hE);
      check("steal70_s2_rst_div", 64'(voice_rst_div), 64'h1);
      @(negedge clk);
      check("steal70_s3_steal", 64'(steal), 64'd0);
      wait_n(3);
      check("steal70_s6_ena", 64'(voice_ena), 64'hF);

      // Retrigger 26 on voice 1: same voice, age reset, no steal
      send(1'b1, 12'd26, 2'd1);
      wait_n(2);
      check("retrig_s2_rst_div", 64'(voice_rst_div), 64'h2);
      check("retrig_s2_ena", 64'(voice_ena), 64'hD);
      check("retrig_s2_pitch", 64'(voice_pitch), 64'(pp(70, 26, 40, 60)));
      check("retrig_s2_wave", 64'(voice_wave), 64'(ww(2, 1, 3, 0)));
      check("retrig_s2_steal", 64'(steal), 64'd0);
      wait_n(4);
      check("retrig_s6_ena", 64'(voice_ena), 64'hF);

      // Ages now v0=1 v1=0 v2=3 v3=2: 80 must steal voice 2, not the retriggered voice 1
      send(1'b1, 12'd80, 2'd0);
      wait_n(2);
      check("steal80_s2_pitch", 64'(voice_pitch), 64'(pp(70, 26, 80, 60)));
      check("steal80_s2_wave", 64'(voice_wave), 64'(ww(2, 1, 0, 0)));
      check("steal80_s2_steal", 64'(steal), 64'd1);
      wait_n(4);

      // Note-off 26 (voice 1)
      send(1'b0, 12'd26, 2'd0);
      check("off26_s0_ena", 64'(voice_ena), 64'hF);
      @(negedge clk);
      check("off26_s1_ena", 64'(voice_ena), 64'hF);
      @(negedge clk);
      check("off26_s2_ena", 64'(voice_ena), 64'hD);
      check("off26_s2_pitch", 64'(voice_pitch), 64'(pp(70, 26, 80, 60)));
      check("off26_s2_ready", 64'(ev_ready), 64'd1);

      // Note-off for an absent pitch
      send(1'b0, 12'd99, 2'd0);
      check("off99_s0_ready", 64'(ev_ready), 64'd0);
      @(negedge clk);
      check("off99_s1_ready", 64'(ev_ready), 64'd0);
      @(negedge clk);
      check("off99_s2_ready", 64'(ev_ready), 64'd1);
      check("off99_s2_ena", 64'(voice_ena), 64'hD);
      check("off99_s2_pitch", 64'(voice_pitch), 64'(pp(70, 26, 80, 60)));
      check("off99_s2_rst_div", 64'(voice_rst_div), 64'h0);

      // Free voice 1 reused
      send(1'b1, 12'd55, 2'd2);
      wait_n(2);
      check("on55_s2_rst_div", 64'(voice_rst_div), 64'h2);
      check("on55_s2_pitch", 64'(voice_pitch), 64'(pp(70, 55, 80, 60)));
      check("on55_s2_steal", 64'(steal), 64'd0);
      wait_n(4);
      check("on55_s6_ena", 64'(voice_ena), 64'hF);

      // Ages v0=3 v1=0 v2=1 v3=4: 33 steals voice 3; a second event stalls during HOLD
      send(1'b1, 12'd33, 2'd1);
      wait_n(2);
      check("steal33_s2_pitch", 64'(voice_pitch), 64'(pp(70, 55, 80, 33)));
      check("steal33_s2_rst_div", 64'(voice_rst_div), 64'h8);
      ev_valid     = 1'b1;
      ev_on        = 1'b1;
      ev_pitch     = 12'd44;
      waveform_sel = 2'd3;
      for (int i = 3; i <= 5; i++) begin
         @(negedge clk);
         check("stall_ready", 64'(ev_ready), 64'd0);
         check("stall_pitch", 64'(voice_pitch), 64'(pp(70, 55, 80, 33)));
         check("stall_rst_div", 64'(voice_rst_div), 64'h8);
      end
      send(1'b1, 12'd44, 2'd3);
      check("on44_s0_ena", 64'(voice_ena), 64'hF);
      check("on44_s0_ready", 64'(ev_ready), 64'd0);
      wait_n(2);
      check("on44_s2_pitch", 64'(voice_pitch), 64'(pp(44, 55, 80, 33)));
      check("on44_s2_wave", 64'(voice_wave), 64'(ww(3, 2, 0, 1)));
      check("on44_s2_steal", 64'(steal), 64'd1);
      check("on44_s2_rst_div", 64'(voice_rst_div), 64'h1);
      check("on44_s2_ena", 64'(voice_ena), 64'hE);

      // Reset during HOLD
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("midrst_pitch", 64'(voice_pitch), 64'h0);
      check("midrst_wave", 64'(voice_wave), 64'h0);
      check("midrst_ena", 64'(voice_ena), 64'h0);
      check("midrst_rst_div", 64'(voice_rst_div), 64'hF);
      check("midrst_ready", 64'(ev_ready), 64'd0);
      check("midrst_steal", 64'(steal), 64'd0);
      wait_n(2);
      rst_n = 1'b1;
      wait_n(3);
      check("reinit_s3_rst_div", 64'(voice_rst_div), 64'hF);
      @(negedge clk);
      check("reinit_rst_div", 64'(voice_rst_div), 64'h0);
      check("reinit_ready", 64'(ev_ready), 64'd1);
      check("reinit_ena", 64'(voice_ena), 64'h0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
